// File: rtl/guarded_stack.sv
// guarded_stack: LIFO with visible top entries, sticky overflow/underflow flags and async reset
module guarded_stack #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int VISIBLES = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WIDTH-1:0]                   insert,
  input  logic                               err_clear,
  output logic [VISIBLES-1:0][WIDTH-1:0]     tops,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               empty,
  output logic                               full,
  output logic                               overflow,
  output logic                               underflow
);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        is_empty, is_full;
  assign is_empty = count_q == '0;
  assign is_full  = count_q == CW'(DEPTH);
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = err_clear ? 1'b0 : ovf_q;
    unf_d   = err_clear ? 1'b0 : unf_q;
    if (push && pop) begin
      if (is_empty) unf_d = 1'b1;
      else mem_d[0] = insert;
    end else if (push) begin
      if (is_full) ovf_d = 1'b1;
      else begin
        for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
        mem_d[0] = insert;
        count_d  = count_q + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) unf_d = 1'b1;
      else begin
        for (int i = 0; i < DEPTH-1; i++) mem_d[i] = mem_q[i+1];
        mem_d[DEPTH-1] = '0;
        count_d        = count_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  for (genvar v = 0; v < VISIBLES; v++) begin : g_tops
    assign tops[v] = (CW'(v) < count_q) ? mem_q[v] : '0;
  end
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_guarded_stack.sv
// tb_guarded_stack: directed and random checks of guarded_stack against a queue-based model
module tb_guarded_stack;
  logic              clk = 0, reset_n = 0, push = 0, pop = 0, err_clear = 0;
  logic [31:0]       insert = '0;
  logic [1:0][31:0]  tops;
  logic [3:0]        count;
  logic              empty, full, overflow, underflow;
  int                checks = 0, failures = 0;
  logic [31:0]       q[$];
  logic              m_ovf = 0, m_unf = 0;

  guarded_stack #(.WIDTH(32), .DEPTH(8), .VISIBLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .insert(insert),
    .err_clear(err_clear), .tops(tops), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
    chk({tag, "_empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, "_full"}, 64'(full), 64'(q.size() == 8));
    chk({tag, "_top0"}, 64'(tops[0]), 64'(q.size() > 0 ? q[0] : 32'd0));
    chk({tag, "_top1"}, 64'(tops[1]), 64'(q.size() > 1 ? q[1] : 32'd0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, "_unf"}, 64'(underflow), 64'(m_unf));
  endtask

  task automatic model(logic pu, logic po, logic [31:0] ins, logic clr);
    logic no = clr ? 1'b0 : m_ovf;
    logic nu = clr ? 1'b0 : m_unf;
    if (pu && po) begin
      if (q.size() == 0) nu = 1'b1;
      else q[0] = ins;
    end else if (pu) begin
      if (q.size() == 8) no = 1'b1;
      else q.push_front(ins);
    end else if (po) begin
      if (q.size() == 0) nu = 1'b1;
      else void'(q.pop_front());
    end
    m_ovf = no;
    m_unf = nu;
  endtask

  task automatic step(string tag, logic pu, logic po, logic [31:0] ins, logic clr);
    push = pu; pop = po; insert = ins; err_clear = clr;
    @(posedge clk);
    model(pu, po, ins, clr);
    @(negedge clk);
    push = 0; pop = 0; err_clear = 0;
    chk_all(tag);
  endtask

  initial begin
    #1 chk_all("reset");
    @(negedge clk) reset_n = 1;
    step("idle", 0, 0, 32'h55, 0);
    step("unf_pop", 0, 1, 0, 0);
    chk("unf_set", 64'(underflow), 64'd1);
    step("unf_pp", 1, 1, 5, 0);
    step("unf_clr", 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("fill", 1, 0, 32'(i), 0);
    chk("fill_top0", 64'(tops[0]), 64'd7);
    chk("fill_top1", 64'(tops[1]), 64'd6);
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 64'(tops[0]), 64'(7 - i));
      step("drain", 0, 1, 0, 0);
    end
    step("coll_pop", 0, 1, 0, 0);
    step("coll_clr_pop", 0, 1, 0, 1);
    chk("coll_unf", 64'(underflow), 64'd1);
    step("coll_clr", 0, 0, 0, 1);
    step("rep_p1", 1, 0, 1, 0);
    step("rep_p2", 1, 0, 2, 0);
    step("rep_pp", 1, 1, 9, 0);
    chk("rep_top0", 64'(tops[0]), 64'd9);
    chk("rep_top1", 64'(tops[1]), 64'd1);
    for (int i = 0; i < 6; i++) step("rep_fill", 1, 0, 32'(i + 20), 0);
    step("rep_full_pp", 1, 1, 32'h77, 0);
    chk("rep_full_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) step("ovf_drain", 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("ovf_fill", 1, 0, 32'(i), 0);
    step("ovf_push", 1, 0, 32'hDEAD, 0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_top0", 64'(tops[0]), 64'd7);
    step("ovf_clr", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("ar_drain", 0, 1, 0, 0);
    step("ar_unf", 0, 1, 0, 0);
    #1 reset_n = 0;
    q = {}; m_ovf = 0; m_unf = 0;
    #1 chk_all("ar_async");
    #1 reset_n = 1;
    @(negedge clk);
    step("ar_push4", 1, 0, 4, 0);
    chk("ar_top0", 64'(tops[0]), 64'd4);
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      step("rand", r < 45 || (r >= 80 && r < 90), (r >= 45 && r < 90), $urandom, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/guarded_stack.md
GUARDED_STACK -- requirements
Module: guarded_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, maximum entries held (DEPTH >= 2).
REQ-003 The block SHALL have parameter VISIBLES, default 1, number of top entries exposed (1 <= VISIBLES <= DEPTH).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, reset: asynchronous, active-low.
REQ-006 The block SHALL have port push, input, 1, request to place insert on top.
REQ-007 The block SHALL have port pop, input, 1, request to remove top entry.
REQ-008 The block SHALL have port insert, input, WIDTH, word to push or replace with.
REQ-009 The block SHALL have port err_clear, input, 1, clears sticky error flags.
REQ-010 The block SHALL have port tops, output, VISIBLES x WIDTH, tops[0] = top, tops[i] = i-th below top.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH+1), current number of valid entries.
REQ-012 The block SHALL have port empty, output, 1, high when count == 0.
REQ-013 The block SHALL have port full, output, 1, high when count == DEPTH.
REQ-014 The block SHALL have port overflow, output, 1, sticky: push rejected because full.
REQ-015 The block SHALL have port underflow, output, 1, sticky: pop rejected because empty.

Function
REQ-016 tops, count, empty and full SHALL be driven combinationally from registered state only; a clocked operation becomes visible immediately after the edge (zero-cycle output latency, one-cycle operation latency).
REQ-017 tops[i] SHALL read 0 for every i >= count.
REQ-018 Push only, count < DEPTH: insert becomes tops[0]; prior entries shift down one; count += 1.
REQ-019 Push only, count == DEPTH: no state change except overflow <= 1; the bottom entry is not discarded.
REQ-020 Pop only, count > 0: tops[i] <= previous tops[i+1]; count -= 1; the vacated slot is zeroed.
REQ-021 Pop only, count == 0: no state change except underflow <= 1.
REQ-022 Push and pop together, count >= 1: top entry replaced by insert; count unchanged; no flag change, including when full.
REQ-023 Push and pop together, count == 0: no state change; underflow <= 1.
REQ-024 Neither push nor pop: stored data and count SHALL hold.
REQ-025 err_clear SHALL clear overflow and underflow on the next edge; an error detected in the same cycle as err_clear SHALL win, leaving its flag set.
REQ-026 count SHALL never exceed DEPTH nor go below 0 under any input sequence.

Reset
REQ-027 reset_n low SHALL asynchronously force count = 0, all storage = 0, overflow = 0, underflow = 0, independent of clk.
REQ-028 Consequently during reset tops = all 0, empty = 1, full = 0.
REQ-029 Reset asserted mid-operation SHALL discard any operation sampled on that edge; after release the first rising edge with push/pop acts normally.

Verification (WIDTH=32, DEPTH=8, VISIBLES=2)
REQ-030 Fill/drain: push 0..7 on 8 edges -> count = 8, full = 1, tops = {7,6}; then pop 8 times -> tops[0] sequence 7,6,...,0; finally count = 0, empty = 1, tops = {0,0}.
REQ-031 Overflow: with 8 entries (0..7) push 0xDEAD -> overflow = 1, count = 8, tops = {7,6}; err_clear one cycle -> overflow = 0.
REQ-032 Underflow: from reset pop -> underflow = 1, count = 0; push+pop with insert 5 while empty -> underflow stays 1, count = 0.
REQ-033 Replace: push 1, push 2, then push+pop with insert 9 -> tops = {9,1}, count = 2, no flags; repeat while full -> count = 8, overflow = 0.
REQ-034 Clear/error collision: underflow = 1, assert err_clear and pop on empty in the same cycle -> underflow remains 1.
REQ-035 Async reset: push 3 entries, drop reset_n between clock edges -> count = 0, tops = {0,0}, flags 0 immediately without a clock edge; release and push 4 -> tops = {4,0}, count = 1.
